instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, as the width of the data, address and instruction words.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, as the maximum number of cycles to wait for mem_ack per request.
REQ-003 The block SHALL have parameter HALT_OPCODE, default 16'hFFFF, as the opcode that stops fetching.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, the reset: synchronous, active-high.
REQ-006 The block SHALL have port run, input, 1 bit, which permits fetching when high.
REQ-007 The block SHALL have port pc, input, 16 bits, the current program counter value from the PC stage.
REQ-008 The block SHALL have port mem_req, output, 1 bit, the instruction-memory read request.
REQ-009 The block SHALL have port mem_addr, output, 16 bits, the instruction-memory word address.
REQ-010 The block SHALL have port mem_ack, input, 1 bit, which marks mem_rdata valid this cycle.
REQ-011 The block SHALL have port mem_rdata, input, 16 bits, the memory read data.
REQ-012 The block SHALL have port exec_busy, input, 1 bit, the downstream stall.
REQ-013 The block SHALL have port opcode, output, 16 bits, the latched opcode word.
REQ-014 The block SHALL have port operand, output, 16 bits, the latched operand word.
REQ-015 The block SHALL have port pc_enable, output, 1 bit, a one-cycle advance strobe to the PC stage.
REQ-016 The block SHALL have port issue_valid, output, 1 bit, which marks opcode/operand issued this cycle.
REQ-017 The block SHALL have port halted, output, 1 bit, asserted (sticky) when HALT_OPCODE has been fetched.
REQ-018 The block SHALL have port fault, output, 1 bit, asserted (sticky) on a memory timeout.

Function
REQ-019 The FSM SHALL have states IDLE, REQ_OP, REQ_ARG, ISSUE, HALT and FAULT, one-hot or encoded.
REQ-020 In IDLE, run=1 SHALL move the FSM to REQ_OP next cycle; run=0 SHALL keep it in IDLE.
REQ-021 In REQ_OP, mem_req=1 and mem_addr={pc[14:0],1'b0} (combinational); pc[15] SHALL be ignored, so addresses wrap modulo 2^16.
REQ-022 In REQ_OP, mem_ack=1 SHALL latch mem_rdata into opcode and move to REQ_ARG; an ack in the same cycle as the request is legal.
REQ-023 In REQ_ARG, mem_req=1 and mem_addr={pc[14:0],1'b1}; mem_ack=1 SHALL latch mem_rdata into operand.
REQ-024 On that REQ_ARG ack, the next state SHALL be HALT if opcode==HALT_OPCODE, else ISSUE.
REQ-025 In ISSUE with exec_busy=1, the FSM SHALL hold, with pc_enable=0 and issue_valid=0.
REQ-026 In ISSUE with exec_busy=0, pc_enable=1 and issue_valid=1 for exactly that cycle; next state SHALL be REQ_OP if run=1, else IDLE.
REQ-027 pc_enable SHALL never be high outside ISSUE, and never for two consecutive cycles.
REQ-028 The fetch of instruction N+1 SHALL use the pc value updated by the strobe of instruction N (pc sampled while in REQ_OP/REQ_ARG, one cycle after the strobe).
REQ-029 mem_ack outside REQ_OP/REQ_ARG SHALL be ignored, with no state or data change.
REQ-030 mem_req SHALL be 0 in IDLE, ISSUE, HALT and FAULT.
REQ-031 A wait counter SHALL clear on entry to each request state and increment each cycle without ack.
REQ-032 When the wait counter reaches TIMEOUT without ack, the FSM SHALL enter FAULT; an ack in the cycle the count reaches TIMEOUT SHALL win.
REQ-033 HALT and FAULT SHALL be terminal until reset; halted=1 in HALT and fault=1 in FAULT; run SHALL be ignored in both.
REQ-034 A minimum instruction SHALL take 3 cycles: REQ_OP, REQ_ARG and ISSUE, with immediate acks and exec_busy=0.
REQ-035 opcode and operand SHALL hold their values until overwritten by the next ack.

Reset
REQ-036 When reset=1 at a rising edge, the FSM SHALL go to IDLE, with opcode=0, operand=0, wait counter=0, pc_enable=0, issue_valid=0, halted=0, fault=0 and mem_req=0, overriding all other inputs.
REQ-037 A reset during an outstanding request SHALL abandon that request; an ack in the reset cycle SHALL be discarded.

Verification
REQ-038 With pc=0x0004, run=1, and ack immediately returning 0x7000 then 0x0020, the bench SHALL see mem_addr 0x0008 then 0x0009, and opcode=0x7000, operand=0x0020, pc_enable=1 on the 3rd cycle.
REQ-039 With exec_busy=1 held for 4 cycles in ISSUE, the bench SHALL see pc_enable low for those 4 cycles, then high for exactly 1 cycle after exec_busy falls.
REQ-040 With opcode fetch returning 0xFFFF, the bench SHALL see halted=1, no pc_enable, mem_req=0 forever, and run toggling SHALL have no effect.
REQ-041 With no ack for 15 cycles in REQ_ARG, the bench SHALL see fault=1 and mem_req=0, while an ack on the 15th cycle SHALL proceed normally with no fault.
REQ-042 With reset asserted while in REQ_ARG with ack high, the bench SHALL see IDLE, operand unchanged at 0, and no pc_enable.
REQ-043 With pc=0xFFFF, the bench SHALL see mem_addr 0xFFFE and 0xFFFF, with no X or overflow effects.

Source files
------------

// File: rtl/instr_fetch.sv
// Two-word instruction fetch unit: reads opcode and operand from instruction memory,
// issues them downstream, and stops on a halt opcode or a memory timeout.
module instr_fetch #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    TIMEOUT     = 15,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  exec_busy,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  pc_enable,
    output logic                  issue_valid,
    output logic                  halted,
    output logic                  fault
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    // Last wait cycle: no ack here means the count reaches TIMEOUT and the request faults.
    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_OP,
        REQ_ARG,
        ISSUE,
        HALT,
        FAULT
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    // NOTE: all state lives in this one clocked block and uses non-blocking assignments,
    // so every branch reads the pre-edge values of state, opcode and wait_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            opcode   <= '0;
            operand  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= REQ_OP;
                        wait_cnt <= '0;
                    end
                end
                REQ_OP: begin
                    if (mem_ack) begin
                        opcode   <= mem_rdata;
                        state    <= REQ_ARG;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                REQ_ARG: begin
                    if (mem_ack) begin
                        operand <= mem_rdata;
                        state   <= (opcode == HALT_OPCODE) ? HALT : ISSUE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (!exec_busy) begin
                        state    <= run ? REQ_OP : IDLE;
                        wait_cnt <= '0;
                    end
                end
                HALT, FAULT: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word address is pc*2 (+1 for the operand); the top pc bit falls off the truncation.
    assign mem_addr    = DATA_WIDTH'({pc, state == REQ_ARG});
    assign mem_req     = (state == REQ_OP) || (state == REQ_ARG);
    assign pc_enable   = (state == ISSUE) && !exec_busy;
    assign issue_valid = (state == ISSUE) && !exec_busy;
    assign halted      = (state == HALT);
    assign fault       = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: basic fetch, stalls, timeout
// boundary, halt, reset during a request and pc wrap-around.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        exec_busy;
    logic [15:0] opcode;
    logic [15:0] operand;
    logic        pc_enable;
    logic        issue_valid;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .exec_busy  (exec_busy),
        .opcode     (opcode),
        .operand    (operand),
        .pc_enable  (pc_enable),
        .issue_valid(issue_valid),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Status bits: {mem_req, pc_enable, issue_valid, halted, fault}
    function automatic logic [4:0] status();
        return {mem_req, pc_enable, issue_valid, halted, fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        run     = 1'b0;
        mem_ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h5555; exec_busy = 1'b0; pc = 16'h0000;
        tick();
        tick();
        #1;
        total++;
        if ({status(), opcode, operand} !== {5'b00000, 16'h0000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", {status(), opcode, operand}, {5'b00000, 32'h0});
        end
    endtask

    task automatic test_basic();
        reset = 1'b0; run = 1'b1; pc = 16'h0004; exec_busy = 1'b0; mem_ack = 1'b0;
        #1;
        total++;
        if (status() !== 5'b00000) begin
            bad++; $display("FAIL basic_idle: got %b want %b", status(), 5'b00000);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h7000; #1;
        total++;
        if ({status(), mem_addr} !== {5'b10000, 16'h0008}) begin
            bad++; $display("FAIL basic_op_req: got %h want %h", {status(), mem_addr}, {5'b10000, 16'h0008});
        end
        tick();
        mem_rdata = 16'h0020; #1;
        total++;
        if ({status(), mem_addr, opcode} !== {5'b10000, 16'h0009, 16'h7000}) begin
            bad++; $display("FAIL basic_arg_req: got %h want %h", {status(), mem_addr, opcode}, {5'b10000, 16'h0009, 16'h7000});
        end
        tick();
        mem_ack = 1'b0; #1;
        total++;
        if ({status(), opcode, operand} !== {5'b01100, 16'h7000, 16'h0020}) begin
            bad++; $display("FAIL basic_issue: got %h want %h", {status(), opcode, operand}, {5'b01100, 16'h7000, 16'h0020});
        end
        tick();
        pc = 16'h0005; #1;
        total++;
        if ({status(), mem_addr} !== {5'b10000, 16'h000A}) begin
            bad++; $display("FAIL next_fetch_pc: got %h want %h", {status(), mem_addr}, {5'b10000, 16'h000A});
        end
    endtask

    task automatic test_busy_stall();
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_rdata = 16'h5678;
        tick();
        mem_ack = 1'b0; exec_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({status(), operand} !== {5'b00000, 16'h5678}) begin
                bad++; $display("FAIL busy_hold[%0d]: got %h want %h", i, {status(), operand}, {5'b00000, 16'h5678});
            end
            tick();
        end
        exec_busy = 1'b0; run = 1'b0; #1;
        total++;
        if (status() !== 5'b01100) begin
            bad++; $display("FAIL busy_release: got %b want %b", status(), 5'b01100);
        end
        tick();
        #1;
        total++;
        if (status() !== 5'b00000) begin
            bad++; $display("FAIL single_strobe: got %b want %b", status(), 5'b00000);
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        tick();
        mem_ack = 1'b0; #1;
        total++;
        if ({status(), opcode, operand} !== {5'b00000, 16'h1234, 16'h5678}) begin
            bad++; $display("FAIL idle_ack_ignored: got %h want %h", {status(), opcode, operand}, {5'b00000, 16'h1234, 16'h5678});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1; pc = 16'h0100; exec_busy = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h0001;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 14; i++) begin
            #1;
            total++;
            if (status() !== 5'b10000) begin
                bad++; $display("FAIL ack_window[%0d]: got %b want %b", i, status(), 5'b10000);
            end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'h0002;
        tick();
        mem_ack = 1'b0; #1;
        total++;
        if ({status(), operand} !== {5'b01100, 16'h0002}) begin
            bad++; $display("FAIL late_ack_wins: got %h want %h", {status(), operand}, {5'b01100, 16'h0002});
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h0003;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            total++;
            if (status() !== 5'b10000) begin
                bad++; $display("FAIL pre_fault[%0d]: got %b want %b", i, status(), 5'b10000);
            end
            tick();
        end
        #1;
        total++;
        if (status() !== 5'b00001) begin
            bad++; $display("FAIL fault_entered: got %b want %b", status(), 5'b00001);
        end
        for (int i = 0; i < 6; i++) begin
            run = i[0]; mem_ack = 1'b1; mem_rdata = 16'h9999;
            tick();
            #1;
            total++;
            if ({status(), operand} !== {5'b00001, 16'h0002}) begin
                bad++; $display("FAIL fault_sticky[%0d]: got %h want %h", i, {status(), operand}, {5'b00001, 16'h0002});
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; pc = 16'h0010; exec_busy = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_rdata = 16'h0042;
        tick();
        mem_ack = 1'b0; #1;
        total++;
        if ({status(), opcode, operand} !== {5'b00010, 16'hFFFF, 16'h0042}) begin
            bad++; $display("FAIL halt_entered: got %h want %h", {status(), opcode, operand}, {5'b00010, 16'hFFFF, 16'h0042});
        end
        for (int i = 0; i < 6; i++) begin
            run = i[0]; mem_ack = i[1]; mem_rdata = 16'h0BAD;
            tick();
            #1;
            total++;
            if ({status(), opcode} !== {5'b00010, 16'hFFFF}) begin
                bad++; $display("FAIL halt_sticky[%0d]: got %h want %h", i, {status(), opcode}, {5'b00010, 16'hFFFF});
            end
        end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        run = 1'b1; pc = 16'h0020; exec_busy = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_rdata = 16'h2222; reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0; #1;
        total++;
        if ({status(), opcode, operand} !== {5'b00000, 16'h0000, 16'h0000}) begin
            bad++; $display("FAIL reset_mid_req: got %h want %h", {status(), opcode, operand}, {5'b00000, 32'h0});
        end
        tick();
        #1;
        total++;
        if (status() !== 5'b00000) begin
            bad++; $display("FAIL reset_mid_idle: got %b want %b", status(), 5'b00000);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        run = 1'b1; pc = 16'hFFFF; exec_busy = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hABCD; #1;
        total++;
        if ({status(), mem_addr} !== {5'b10000, 16'hFFFE}) begin
            bad++; $display("FAIL wrap_op_addr: got %h want %h", {status(), mem_addr}, {5'b10000, 16'hFFFE});
        end
        tick();
        mem_rdata = 16'h0001; #1;
        total++;
        if ({status(), mem_addr} !== {5'b10000, 16'hFFFF}) begin
            bad++; $display("FAIL wrap_arg_addr: got %h want %h", {status(), mem_addr}, {5'b10000, 16'hFFFF});
        end
        tick();
        mem_ack = 1'b0; run = 1'b0; #1;
        total++;
        if ({status(), opcode, operand} !== {5'b01100, 16'hABCD, 16'h0001}) begin
            bad++; $display("FAIL wrap_issue: got %h want %h", {status(), opcode, operand}, {5'b01100, 16'hABCD, 16'h0001});
        end
        tick();
        #1;
        total++;
        if (status() !== 5'b00000) begin
            bad++; $display("FAIL wrap_back_idle: got %b want %b", status(), 5'b00000);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; run = 1'b0; pc = '0; mem_ack = 1'b0; mem_rdata = '0; exec_busy = 1'b0;
        test_reset();
        test_basic();
        test_busy_stall();
        test_timeout();
        test_halt();
        test_reset_mid_request();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
